// File: rtl/param_fifo_pow2.sv
// param_fifo_pow2: synchronous FIFO whose capacity is the requested Depth
// rounded up to a power of two. The address width is derived from Depth and
// then sizes the pointers, the storage array and the usage_o port.
//
// Optional build macro: PARAM_FIFO_FALL_THROUGH_EN
//    When defined, an item offered to an empty FIFO appears on the output in
//    the same cycle. If the consumer takes it in that cycle it never touches
//    storage. When undefined, the FIFO has strict one-cycle latency and no
//    combinational path from the in_* ports to the out_* ports.

module param_fifo_pow2 #(
   parameter int unsigned Depth     = 32'd5,
   parameter int unsigned DataWidth = 32'd8,
   localparam int unsigned AddrWidth = (Depth > 1) ? unsigned'($clog2(Depth)) : 1,
   localparam int unsigned PhysDepth = 2**AddrWidth
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 flush_i,
   input  logic                 in_valid_i,
   output logic                 in_ready_o,
   input  logic [DataWidth-1:0] in_data_i,
   output logic                 out_valid_o,
   input  logic                 out_ready_i,
   output logic [DataWidth-1:0] out_data_o,
   output logic [AddrWidth:0]   usage_o
);

   // A zero-sized FIFO or zero-width entry is meaningless; stop elaboration.
   if (Depth == 0 || DataWidth == 0) begin : g_bad_params
      $error("param_fifo_pow2: Depth and DataWidth must both be at least 1");
   end

   localparam logic [AddrWidth:0] PtrOne = {{AddrWidth{1'b0}}, 1'b1};

   logic [DataWidth-1:0] mem [PhysDepth];

   // Pointers carry one extra wrap bit above the index so that full and
   // empty can be told apart when the indices match.
   logic [AddrWidth:0]   wptr;
   logic [AddrWidth:0]   rptr;
   logic [AddrWidth-1:0] widx;
   logic [AddrWidth-1:0] ridx;

   logic empty;
   logic full;
   logic bypass;
   logic push_fire;
   logic pop_fire;
   logic clear;

   // Status decode from the pointer pair.
   always_comb begin
      widx  = wptr[AddrWidth-1:0];
      ridx  = rptr[AddrWidth-1:0];
      empty = (wptr == rptr);
      full  = (widx == ridx) && (wptr[AddrWidth] != rptr[AddrWidth]);
      clear = rst_i || flush_i;
   end

   // Producer-side handshake and occupancy. Ready depends only on stored
   // state, so a pop in the same cycle never opens a full FIFO for a push.
   always_comb begin
      in_ready_o = !full;
      usage_o    = wptr - rptr;
   end

`ifdef PARAM_FIFO_FALL_THROUGH_EN
   // Consumer side with fall-through: an empty FIFO forwards the incoming
   // item directly, and if it is taken right away storage is skipped.
   always_comb begin
      bypass      = empty && in_valid_i && out_ready_i;
      out_valid_o = !empty || in_valid_i;
      out_data_o  = empty ? in_data_i : mem[ridx];
   end
`else
   // Consumer side with registered latency: only stored entries are visible,
   // and the head is a plain read of the array at the read index.
   always_comb begin
      bypass      = 1'b0;
      out_valid_o = !empty;
      out_data_o  = mem[ridx];
   end
`endif

   // Transfer qualification. A bypassed item is consumed in flight, so it
   // neither writes the array nor advances the write pointer.
   always_comb begin
      push_fire = in_valid_i && !full && !bypass;
      pop_fire  = !empty && out_ready_i;
   end

   // Pointer registers; reset and flush both discard every stored entry and
   // ignore any push or pop requested in that cycle.
   always_ff @(posedge clk_i) begin
      if (clear) begin
         wptr <= '0;
         rptr <= '0;
      end else begin
         if (push_fire) begin
            wptr <= wptr + PtrOne;
         end
         if (pop_fire) begin
            rptr <= rptr + PtrOne;
         end
      end
   end

   // Storage write. The array is deliberately not reset; stale contents are
   // unreachable once the pointers are cleared.
   always_ff @(posedge clk_i) begin
      if (push_fire && !clear) begin
         mem[widx] <= in_data_i;
      end
   end

endmodule
